sys_mem_responder: RTL

//  System-bus responder: the memory end of the cache controller's Sys* interface.

---
 rtl/sys_mem_responder_if.sv | 25 ++
 rtl/sys_mem_responder.sv | 122 ++++++++++++
 2 files changed

// File: rtl/sys_mem_responder_if.sv
// System-bus bundle between the cache controller (master) and the memory responder (slave).
interface sys_mem_responder_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              SysStrobe;
    logic              SysRW;
    logic [ADDR_W-1:0] SysAddr;
    logic [DATA_W-1:0] SysWData;
    logic              SysDataOE;
    logic [DATA_W-1:0] SysRData;
    logic              SysRDataOE;
    logic              SysReady;
    logic              ProtoErr;

    modport master (
        output SysStrobe, SysRW, SysAddr, SysWData, SysDataOE,
        input  SysRData, SysRDataOE, SysReady, ProtoErr
    );

    modport slave (
        input  SysStrobe, SysRW, SysAddr, SysWData, SysDataOE,
        output SysRData, SysRDataOE, SysReady, ProtoErr
    );
endinterface

// File: rtl/sys_mem_responder.sv
// Memory end of the Sys* bus: edge-detected requests, programmable wait states,
// single-word read/write against an internal array with a one-cycle ready pulse.
module sys_mem_responder #(
    parameter int unsigned WAITSTATES = 2,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    sys_mem_responder_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CTR_W = (WAITSTATES > 0) ? $clog2(WAITSTATES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                strobe_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_oe_q, rdata_oe_d;
    logic                ready_q, ready_d;
    logic                proto_err_q, proto_err_d;
    logic                new_req_c;
    logic                mem_we_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign new_req_c = bus.SysStrobe & ~strobe_q;
    assign mem_we_c  = (state_q == RESP) && rw_q;

    // State, captured request and registered outputs
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            ctr_q       <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strobe_q    <= 1'b0;
            rdata_q     <= '0;
            rdata_oe_q  <= 1'b0;
            ready_q     <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            strobe_q    <= bus.SysStrobe;
            rdata_q     <= rdata_d;
            rdata_oe_q  <= rdata_oe_d;
            ready_q     <= ready_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = '0;
        rdata_oe_d  = 1'b0;
        ready_d     = 1'b0;
        proto_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (new_req_c) begin
                    // A write without driven data is rejected outright
                    if (bus.SysRW && !bus.SysDataOE) begin
                        proto_err_d = 1'b1;
                    end else begin
                        rw_d    = bus.SysRW;
                        addr_d  = bus.SysAddr;
                        wdata_d = bus.SysWData;
                        ctr_d   = CTR_W'(WAITSTATES);
                        state_d = (WAITSTATES == 0) ? RESP : WAIT;
                    end
                end
            end
            WAIT: begin
                proto_err_d = new_req_c;
                ctr_d       = ctr_q - CTR_W'(1);
                if (ctr_q == CTR_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                proto_err_d = new_req_c;
                ready_d     = 1'b1;
                state_d     = IDLE;
                if (!rw_q) begin
                    rdata_oe_d = 1'b1;
                    rdata_d    = mem[addr_q];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write commits on the edge that ends the response; reset forces IDLE so aborts never write
    always_ff @(posedge Clk) begin
        if (mem_we_c) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.SysRData   = rdata_q;
    assign bus.SysRDataOE = rdata_oe_q;
    assign bus.SysReady   = ready_q;
    assign bus.ProtoErr   = proto_err_q;
endmodule
